// File: rtl/sevenseg_capture.sv
// Seven-segment capture monitor: recovers hex digits from the multiplexed,
// active-low anode/segment lines of a four-digit display.
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_an_n,
  input  logic [6:0]  i_seg_n,
  output logic [15:0] o_digits,
  output logic [3:0]  o_valid,
  output logic [3:0]  o_bad,
  output logic        o_update
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNT,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    r_an_q;
  logic [6:0]    r_seg_q;
  logic [15:0]   digits_q, digits_d;
  logic [3:0]    valid_q, valid_d;
  logic [3:0]    bad_q, bad_d;
  logic          update_q;

  logic       onehot;
  logic [1:0] idx;
  logic       match;
  logic       done_cnt;
  logic       cap;
  logic       known;
  logic [3:0] value;

  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0_0000;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h18:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h27:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  always_comb begin
    onehot = 1'b1;
    idx    = 2'd0;
    case (i_an_n)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: onehot = 1'b0;
    endcase
  end

  assign match    = ({i_an_n, i_seg_n} == {r_an_q, r_seg_q});
  assign cnt_inc  = cnt_q + CW'(1);
  assign done_cnt = (cnt_inc == CW'(STABLE_CYCLES));
  assign {known, value} = decode(i_seg_n);
  assign cap = (state_q == S_COUNT) && onehot && match && done_cnt;

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    bad_d    = bad_q;
    if (cap) begin
      if (known) begin
        digits_d[{idx, 2'b00} +: 4] = value;
        valid_d[idx] = 1'b1;
        bad_d[idx]   = 1'b0;
      end else if (i_seg_n == 7'h7F) begin
        valid_d[idx] = 1'b0;
        bad_d[idx]   = 1'b0;
      end else begin
        valid_d[idx] = 1'b0;
        bad_d[idx]   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      r_an_q   <= 4'hF;
      r_seg_q  <= 7'h7F;
      digits_q <= '0;
      valid_q  <= '0;
      bad_q    <= '0;
      update_q <= 1'b0;
    end else begin
      r_an_q   <= i_an_n;
      r_seg_q  <= i_seg_n;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
      update_q <= cap;
      case (state_q)
        S_IDLE: begin
          if (onehot) begin
            state_q <= S_COUNT;
            cnt_q   <= CW'(1);
          end
        end
        S_COUNT: begin
          if (!onehot) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (!match) begin
            cnt_q <= CW'(1);
          end else begin
            cnt_q <= cnt_inc;
            if (done_cnt) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!onehot) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (!match) begin
            state_q <= S_COUNT;
            cnt_q   <= CW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign o_digits = digits_q;
  assign o_valid  = valid_q;
  assign o_bad    = bad_q;
  assign o_update = update_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Scoreboard bench for sevenseg_capture: expected captures are queued by
// the stimulus and checked by a monitor on every o_update pulse.
module tb_sevenseg_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic [3:0]  bad_f;
  logic        update;

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;

  logic [23:0] expq[$];

  sevenseg_capture #(.STABLE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_an_n  (an_n),
    .i_seg_n (seg_n),
    .o_digits(digits),
    .o_valid (valid),
    .o_bad   (bad_f),
    .o_update(update)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [3:0] v,
                      input logic [3:0] b);
    expq.push_back({d, v, b});
  endtask

  // Monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && update) begin
      upd_cnt++;
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_update: got %h %h %h want none",
                 digits, valid, bad_f);
      end else begin
        logic [23:0] e;
        e = expq.pop_front();
        if ({digits, valid, bad_f} !== e) begin
          bad++;
          $display("FAIL capture: got %h want %h",
                   {digits, valid, bad_f}, e);
        end
      end
    end
  end

  initial begin
    int u0;
    rst   = 1'b1;
    an_n  = 4'b1110;
    seg_n = 7'h24;
    tick(2);
    chk("reset_digits", 32'(digits), 32'h0000);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_bad", 32'(bad_f), 32'h0);
    chk("reset_update", 32'(update), 32'h0);
    an_n  = 4'hF;
    seg_n = 7'h7F;
    tick(1);
    rst = 1'b0;
    tick(2);

    // Basic capture with exact pulse timing
    u0 = upd_cnt;
    push(16'h0002, 4'b0001, 4'b0000);
    an_n  = 4'b1110;
    seg_n = 7'h24;
    tick(3);
    chk("basic_no_early", 32'(update), 32'h0);
    tick(1);
    chk("basic_pulse", 32'(update), 32'h1);
    chk("basic_digit", 32'(digits), 32'h0002);
    tick(1);
    chk("basic_pulse_end", 32'(update), 32'h0);
    tick(9);
    chk("basic_one_pulse", 32'(upd_cnt - u0), 32'd1);

    // Full scan across all four digits
    u0 = upd_cnt;
    push(16'h000F, 4'b0001, 4'b0000);
    an_n = 4'b1110; seg_n = 7'h0E; tick(8);
    push(16'h00BF, 4'b0011, 4'b0000);
    an_n = 4'b1101; seg_n = 7'h03; tick(8);
    push(16'h01BF, 4'b0111, 4'b0000);
    an_n = 4'b1011; seg_n = 7'h79; tick(8);
    push(16'h81BF, 4'b1111, 4'b0000);
    an_n = 4'b0111; seg_n = 7'h00; tick(8);
    chk("scan_digits", 32'(digits), 32'h81BF);
    chk("scan_valid", 32'(valid), 32'hF);
    chk("scan_pulses", 32'(upd_cnt - u0), 32'd4);

    // Glitch: 3-edge hold of 3 must not capture
    u0 = upd_cnt;
    push(16'h814F, 4'b1111, 4'b0000);
    an_n = 4'b1101; seg_n = 7'h30; tick(3);
    seg_n = 7'h19; tick(4);
    tick(1);
    chk("glitch_pulses", 32'(upd_cnt - u0), 32'd1);
    chk("glitch_digits", 32'(digits), 32'h814F);

    // Bad then blank on digit 2
    push(16'h814F, 4'b1011, 4'b0100);
    an_n = 4'b1011; seg_n = 7'h55; tick(5);
    chk("bad_flag", 32'(bad_f), 32'h4);
    push(16'h814F, 4'b1011, 4'b0000);
    seg_n = 7'h7F; tick(5);
    chk("blank_flags", 32'({valid, bad_f}), 32'hB0);

    // Illegal anode patterns never capture
    u0 = upd_cnt;
    an_n = 4'b1100; seg_n = 7'h12; tick(20);
    an_n = 4'hF; tick(20);
    chk("illegal_no_pulse", 32'(upd_cnt - u0), 32'd0);

    // Reset on edge 3 of a 4-edge hold
    u0 = upd_cnt;
    an_n = 4'b1110; seg_n = 7'h12; tick(2);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(1);
    chk("rst_mid_update", 32'(update), 32'h0);
    an_n = 4'hF; tick(6);
    chk("rst_mid_state", 32'({digits, valid, bad_f}), 32'h0);
    chk("rst_mid_pulses", 32'(upd_cnt - u0), 32'd0);

    // Recovery after reset
    push(16'hE000, 4'b1000, 4'b0000);
    an_n = 4'b0111; seg_n = 7'h06; tick(6);
    chk("recover_digits", 32'(digits), 32'hE000);

    tick(2);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
